// File: rtl/vga_draw_pkg.sv
// Shared types and constants for the VGA raster drawing blocks.
package vga_draw_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } draw_state_t;

    localparam int SCREEN_W_DEFAULT = 320;
    localparam int SCREEN_H_DEFAULT = 240;

    // 3-bit RGB palette used by the game FSM
    localparam logic [2:0] WHITE      = 3'b111;
    localparam logic [2:0] BLACK      = 3'b000;
    localparam logic [2:0] LANE_RED   = 3'b100;
    localparam logic [2:0] LANE_GREEN = 3'b010;
    localparam logic [2:0] LANE_BLUE  = 3'b001;

endpackage

// File: rtl/raster_counter.sv
// Row-major x/y scan counter over a pre-clipped rectangle, with optional
// outline mode that skips interior pixels of interior rows.
module raster_counter
    import vga_draw_pkg::*;
#(
    parameter int XW = 9,
    parameter int YW = 8
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          load,
    input  logic          advance,
    input  logic          outline,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW:0]   w,
    input  logic [YW:0]   h,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic [XW-1:0] x_start;
    logic [YW-1:0] y_start;
    logic [XW:0]   x_end;
    logic [YW:0]   y_end;
    logic          outline_q;

    logic at_x_end;
    logic at_y_end;
    logic interior_row;

    assign at_x_end     = ({1'b0, x} == x_end);
    assign at_y_end     = ({1'b0, y} == y_end);
    assign interior_row = (y != y_start) && !at_y_end;
    assign last         = at_x_end && at_y_end;

    // End coordinates are kept one bit wider so the last column/row of a
    // rectangle touching the screen edge compares without wrap.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x         <= '0;
            y         <= '0;
            x_start   <= '0;
            y_start   <= '0;
            x_end     <= '0;
            y_end     <= '0;
            outline_q <= 1'b0;
        end else if (load) begin
            x         <= x0;
            y         <= y0;
            x_start   <= x0;
            y_start   <= y0;
            x_end     <= {1'b0, x0} + w - (XW+1)'(1);
            y_end     <= {1'b0, y0} + h - (YW+1)'(1);
            outline_q <= outline;
        end else if (advance) begin
            if (at_x_end) begin
                x <= x_start;
                y <= y + YW'(1);
            end else if (outline_q && interior_row && (x == x_start)) begin
                x <= x_end[XW-1:0];
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill/outline raster engine: clips a command to the screen and
// streams one pixel per accepted cycle to the VGA plot interface.
module rect_fill_engine
    import vga_draw_pkg::*;
#(
    parameter int XW       = 9,
    parameter int YW       = 8,
    parameter int CW       = 3,
    parameter int SCREEN_W = SCREEN_W_DEFAULT,
    parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic [XW-1:0] rect_x,
    input  logic [YW-1:0] rect_y,
    input  logic [XW-1:0] rect_w,
    input  logic [YW-1:0] rect_h,
    input  logic [CW-1:0] fill_colour,
    input  logic          outline,
    input  logic          abort,
    input  logic          pix_ready,
    output logic          pix_valid,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [CW-1:0] pix_colour,
    output logic          busy,
    output logic          done
);

    localparam logic [XW:0] SW = (XW+1)'(SCREEN_W);
    localparam logic [YW:0] SH = (YW+1)'(SCREEN_H);

    draw_state_t   state, state_next;
    logic          valid_next;
    logic          busy_next;
    logic          done_next;
    logic [CW-1:0] colour_next;
    logic          load;
    logic          advance;
    logic          last;

    logic [XW:0] x_ext, w_ext, x_room, w_eff;
    logic [YW:0] y_ext, h_ext, y_room, h_eff;

    // Clip in one extra bit so the room-to-edge subtraction cannot wrap.
    always_comb begin
        x_ext  = {1'b0, rect_x};
        w_ext  = {1'b0, rect_w};
        x_room = SW - x_ext;
        if (x_ext >= SW)
            w_eff = '0;
        else if (w_ext < x_room)
            w_eff = w_ext;
        else
            w_eff = x_room;

        y_ext  = {1'b0, rect_y};
        h_ext  = {1'b0, rect_h};
        y_room = SH - y_ext;
        if (y_ext >= SH)
            h_eff = '0;
        else if (h_ext < y_room)
            h_eff = h_ext;
        else
            h_eff = y_room;
    end

    raster_counter #(
        .XW (XW),
        .YW (YW)
    ) u_raster (
        .clock   (clock),
        .resetn  (resetn),
        .load    (load),
        .advance (advance),
        .outline (outline),
        .x0      (rect_x),
        .y0      (rect_y),
        .w       (w_eff),
        .h       (h_eff),
        .x       (pix_x),
        .y       (pix_y),
        .last    (last)
    );

    always_comb begin
        state_next  = state;
        valid_next  = pix_valid;
        busy_next   = busy;
        done_next   = 1'b0;
        colour_next = pix_colour;
        load        = 1'b0;
        advance     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    load        = 1'b1;
                    busy_next   = 1'b1;
                    colour_next = fill_colour;
                    if ((w_eff == '0) || (h_eff == '0)) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = SCAN;
                        valid_next = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (abort) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                end else if (pix_ready) begin
                    if (last) begin
                        state_next = DONE;
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pix_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pix_colour <= '0;
        end else begin
            state      <= state_next;
            pix_valid  <= valid_next;
            busy       <= busy_next;
            done       <= done_next;
            pix_colour <= colour_next;
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Self-checking bench for rect_fill_engine against a clipped-rectangle pixel model.
module tb_rect_fill_engine;

    localparam int SW = 320;
    localparam int SH = 240;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [8:0] rect_x;
    logic [7:0] rect_y;
    logic [8:0] rect_w;
    logic [7:0] rect_h;
    logic [2:0] fill_colour;
    logic       outline;
    logic       abort;
    logic       pix_ready;
    logic       pix_valid;
    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic [2:0] pix_colour;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int got_q[$];
    int done_cyc;
    int valid_cnt;

    rect_fill_engine dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .rect_x      (rect_x),
        .rect_y      (rect_y),
        .rect_w      (rect_w),
        .rect_h      (rect_h),
        .fill_colour (fill_colour),
        .outline     (outline),
        .abort       (abort),
        .pix_ready   (pix_ready),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_colour  (pix_colour),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    // Expected pixel list: every on-screen pixel of the clipped rectangle,
    // row-major, keeping only border pixels in outline mode.
    function automatic void build_expected(int x, int y, int w, int h, bit ol);
        int x1, y1;
        exp_q.delete();
        if (x >= SW || y >= SH || w == 0 || h == 0) return;
        x1 = ((x + w) < SW ? (x + w) : SW) - 1;
        y1 = ((y + h) < SH ? (y + h) : SH) - 1;
        for (int yy = y; yy <= y1; yy++)
            for (int xx = x; xx <= x1; xx++)
                if (!ol || yy == y || yy == y1 || xx == x || xx == x1)
                    exp_q.push_back(xx * 1024 + yy);
    endfunction

    task automatic run_cmd(input string tag, input int x, input int y, input int w, input int h,
                           input int col, input bit ol, input int pct, input bit poke);
        int budget, cyc, last_acc, bad_idx;
        int busy_bad, stall_bad, colour_bad, idle_bad;
        bit done_seen, pv, pr;
        logic [8:0] px;
        logic [7:0] py;
        build_expected(x, y, w, h, ol);
        got_q.delete();
        done_seen = 0; done_cyc = -1; valid_cnt = 0;
        busy_bad = 0; stall_bad = 0; colour_bad = 0; idle_bad = 0;
        budget = (pct >= 100) ? exp_q.size() + 20 : exp_q.size() * 8 + 20;
        rect_x = 9'(x); rect_y = 8'(y); rect_w = 9'(w); rect_h = 8'(h);
        fill_colour = 3'(col); outline = ol; start = 1'b1; abort = 1'b0; pix_ready = 1'b0;
        @(posedge clock); #1;
        if (!poke) start = 1'b0;
        cyc = 0; last_acc = -100; pv = 0; pr = 0; px = '0; py = '0;
        while (!done_seen && cyc < budget) begin
            if (busy !== 1'b1) busy_bad++;
            if (pv && !pr && (pix_valid !== 1'b1 || pix_x !== px || pix_y !== py)) stall_bad++;
            if (pix_valid === 1'b1) begin
                valid_cnt++;
                if (pix_colour !== 3'(col)) colour_bad++;
            end
            if (done === 1'b1) begin
                done_seen = 1;
                done_cyc = cyc;
                if (pix_valid !== 1'b0) stall_bad++;
            end
            if (pct < 0) pix_ready = (cyc % 2 == 0);
            else pix_ready = ($urandom_range(0, 99) < pct);
            if (poke && !done_seen) begin
                rect_x = 9'($urandom_range(0, 300));
                rect_y = 8'($urandom_range(0, 200));
                rect_w = 9'($urandom_range(1, 9));
                rect_h = 8'($urandom_range(1, 9));
                fill_colour = ~3'(col);
            end
            if (pix_valid === 1'b1 && pix_ready) begin
                got_q.push_back(int'(pix_x) * 1024 + int'(pix_y));
                last_acc = cyc;
            end
            pv = (pix_valid === 1'b1); pr = pix_ready; px = pix_x; py = pix_y;
            @(posedge clock); #1;
            cyc++;
        end
        start = 1'b0; pix_ready = 1'b0;
        if (busy !== 1'b0 || done !== 1'b0 || pix_valid !== 1'b0) idle_bad++;
        repeat (3) begin
            @(posedge clock); #1;
            if (busy !== 1'b0 || done !== 1'b0 || pix_valid !== 1'b0) idle_bad++;
        end

        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL %s done_timeout: no done within %0d cycles", tag, budget);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s pixel_count: got %0d expected %0d", tag, got_q.size(), exp_q.size());
        end
        bad_idx = -1;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] != exp_q[i] && bad_idx < 0) bad_idx = i;
        checks++;
        if (bad_idx >= 0) begin
            errors++;
            $display("FAIL %s pixel_order[%0d]: got (%0d,%0d) expected (%0d,%0d)", tag, bad_idx,
                     got_q[bad_idx] / 1024, got_q[bad_idx] % 1024,
                     exp_q[bad_idx] / 1024, exp_q[bad_idx] % 1024);
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s busy_span: %0d cycles with busy low, expected 0", tag, busy_bad);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL %s stall_hold: %0d unstable cycles, expected 0", tag, stall_bad);
        end
        checks++;
        if (colour_bad != 0) begin
            errors++;
            $display("FAIL %s colour: %0d wrong-colour cycles, expected 0", tag, colour_bad);
        end
        if (exp_q.size() > 0 && done_seen) begin
            checks++;
            if (done_cyc - last_acc != 1) begin
                errors++;
                $display("FAIL %s done_latency: got %0d cycles after last accept, expected 1",
                         tag, done_cyc - last_acc);
            end
        end
        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL %s post_idle: %0d non-idle cycles after done, expected 0", tag, idle_bad);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 0; abort = 0; pix_ready = 0; outline = 0;
        rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; fill_colour = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({pix_valid, pix_x, pix_y, pix_colour, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b x=%0d y=%0d c=%0d busy=%b done=%b expected all 0",
                     pix_valid, pix_x, pix_y, pix_colour, busy, done);
        end
        #3 resetn = 1'b1;
        @(posedge clock); #1;
        checks++;
        if ({pix_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got valid=%b busy=%b done=%b expected 000", pix_valid, busy, done);
        end
    endtask

    task automatic test_full_screen();
        run_cmd("full_screen", 0, 0, 320, 240, 7, 1'b0, 100, 1'b0);
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] != 0 || got_q[got_q.size()-1] != 319 * 1024 + 239) begin
                errors++;
                $display("FAIL full_screen_ends: got first %0d last %0d expected 0 and %0d",
                         got_q[0], got_q[got_q.size()-1], 319 * 1024 + 239);
            end
        end
    endtask

    task automatic test_stall_fill();
        run_cmd("stall_fill", 10, 20, 3, 2, 5, 1'b0, -1, 1'b0);
    endtask

    task automatic test_outline();
        int hits;
        run_cmd("outline", 10, 20, 4, 3, 2, 1'b1, 70, 1'b0);
        hits = 0;
        foreach (got_q[i]) if (got_q[i] == 11 * 1024 + 21 || got_q[i] == 12 * 1024 + 21) hits++;
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL outline_interior: got %0d interior pixels expected 0", hits);
        end
        run_cmd("outline_w1", 40, 30, 1, 4, 3, 1'b1, 60, 1'b0);
        run_cmd("outline_h2", 40, 30, 6, 2, 4, 1'b1, 60, 1'b0);
    endtask

    task automatic test_clip();
        run_cmd("clip_corner", 318, 238, 5, 5, 6, 1'b0, 80, 1'b0);
        run_cmd("clip_offscreen", 330, 10, 5, 5, 1, 1'b0, 100, 1'b0);
        checks++;
        if (done_cyc != 0 || valid_cnt != 0) begin
            errors++;
            $display("FAIL clip_offscreen_done: got done at cycle %0d valid cycles %0d expected 0 and 0",
                     done_cyc, valid_cnt);
        end
        run_cmd("clip_outline", 315, 236, 20, 20, 3, 1'b1, 70, 1'b0);
    endtask

    task automatic test_zero_size();
        run_cmd("zero_size", 5, 5, 0, 4, 7, 1'b0, 100, 1'b1);
        checks++;
        if (done_cyc != 0 || valid_cnt != 0) begin
            errors++;
            $display("FAIL zero_size_done: got done at cycle %0d valid cycles %0d expected 0 and 0",
                     done_cyc, valid_cnt);
        end
    endtask

    task automatic test_busy_poke();
        run_cmd("busy_poke", 100, 100, 6, 4, 2, 1'b0, 50, 1'b1);
    endtask

    task automatic test_abort();
        int cyc, dones;
        build_expected(50, 50, 10, 10, 1'b0);
        got_q.delete();
        rect_x = 9'd50; rect_y = 8'd50; rect_w = 9'd10; rect_h = 8'd10;
        fill_colour = 3'd4; outline = 1'b0; start = 1'b1; abort = 1'b0; pix_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 0;
        while (got_q.size() < 5 && cyc < 50) begin
            if (pix_valid === 1'b1 && pix_ready) got_q.push_back(int'(pix_x) * 1024 + int'(pix_y));
            @(posedge clock); #1;
            cyc++;
        end
        abort = 1'b1; pix_ready = 1'b0;
        @(posedge clock); #1;
        abort = 1'b0;
        checks++;
        if ({pix_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_stop: got valid=%b busy=%b done=%b expected 000", pix_valid, busy, done);
        end
        dones = 0;
        repeat (4) begin
            @(posedge clock); #1;
            if (done !== 1'b0 || busy !== 1'b0) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d active cycles expected 0", dones);
        end
        checks++;
        if (got_q.size() != 5 || got_q[0] != exp_q[0] || got_q[got_q.size()-1] != exp_q[4]) begin
            errors++;
            $display("FAIL abort_prefix: got %0d pixels expected 5 matching model", got_q.size());
        end
    endtask

    task automatic test_abort_start_idle();
        rect_x = 9'd20; rect_y = 8'd20; rect_w = 9'd4; rect_h = 8'd4;
        start = 1'b1; abort = 1'b1; pix_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({pix_valid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL abort_start_idle: got valid=%b busy=%b done=%b expected 000",
                     pix_valid, busy, done);
        end
        pix_ready = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        rect_x = 9'd200; rect_y = 8'd100; rect_w = 9'd30; rect_h = 8'd30;
        fill_colour = 3'd6; outline = 1'b0; start = 1'b1; abort = 1'b0; pix_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (7) @(posedge clock);
        #3 resetn = 1'b0;
        #1;
        checks++;
        if ({pix_valid, pix_x, pix_y, pix_colour, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_mid_scan: got valid=%b x=%0d y=%0d c=%0d busy=%b done=%b expected all 0",
                     pix_valid, pix_x, pix_y, pix_colour, busy, done);
        end
        pix_ready = 1'b0;
        @(posedge clock); #3;
        resetn = 1'b1;
        @(posedge clock); #1;
        run_cmd("after_reset", 7, 9, 5, 4, 1, 1'b1, 60, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 14; n++) begin
            run_cmd("random", $urandom_range(0, 335), $urandom_range(0, 250),
                    $urandom_range(0, 24), $urandom_range(0, 12), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), $urandom_range(25, 100), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_stall_fill();
        test_outline();
        test_clip();
        test_zero_size();
        test_busy_poke();
        test_abort();
        test_abort_start_idle();
        test_reset_mid_scan();
        test_random();
        test_full_screen();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
